// File: rtl/pf_ddr3_odt_dly_ctrl_if.sv
// Request and IOD delay-line signal bundle for the ODT delay sequencer.
// The slave side is the sequencer; the master side is training logic plus the IOD model.
interface pf_ddr3_odt_dly_ctrl_if #(
    parameter int TAP_W = 8
);
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [1:0]       REQ_OP;
    logic [TAP_W-1:0] REQ_TAPS;
    logic             DELAY_LINE_MOVE_0;
    logic             DELAY_LINE_DIRECTION_0;
    logic             DELAY_LINE_LOAD_0;
    logic             DELAY_LINE_OUT_OF_RANGE_0;
    logic [TAP_W-1:0] TAP_CNT;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_TAPS, DELAY_LINE_OUT_OF_RANGE_0,
        output REQ_READY, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0,
        output TAP_CNT, BUSY, DONE, ERR
    );

    modport master (
        output REQ_VALID, REQ_OP, REQ_TAPS, DELAY_LINE_OUT_OF_RANGE_0,
        input  REQ_READY, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0,
        input  TAP_CNT, BUSY, DONE, ERR
    );
endinterface

// File: rtl/pf_ddr3_odt_dly_ctrl.sv
// Sequencer for the DDR3 ODT IOD dynamic output delay line: turns step/load
// requests into timed MOVE/DIRECTION/LOAD pulses and tracks the tap count.
module pf_ddr3_odt_dly_ctrl #(
    parameter int TAP_W      = 8,
    parameter int TAP_MAX    = 127,
    parameter int LOAD_VAL   = 1,
    parameter int GAP_CYC    = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic FAB_CLK,
    input  logic ARST_N,
    pf_ddr3_odt_dly_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETUP, S_MOVE, S_GAP, S_SETTLE, S_FIN
    } state_t;

    localparam logic [TAP_W:0]   TAP_MAX_X  = (TAP_W+1)'(TAP_MAX);
    localparam logic [TAP_W-1:0] LOAD_TAP   = TAP_W'(LOAD_VAL);
    localparam logic [7:0]       GAP_LD     = 8'(GAP_CYC - 1);
    localparam logic [7:0]       SETTLE_LD  = 8'(SETTLE_CYC - 1);

    state_t           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] rem_q, rem_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic             oor_q;
    logic [TAP_W:0]   inc_sum;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= S_IDLE;
            tap_q   <= LOAD_TAP;
            rem_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            oor_q   <= bus.DELAY_LINE_OUT_OF_RANGE_0;
        end
    end

    assign inc_sum = {1'b0, tap_q} + {1'b0, bus.REQ_TAPS};

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.REQ_VALID) begin
                    err_d = 1'b0;
                    rem_d = bus.REQ_TAPS;
                    // Range violations are rejected up front so no pulse is ever issued.
                    if (bus.REQ_OP == 2'b11) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else if (bus.REQ_OP == 2'b00 && inc_sum > TAP_MAX_X) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else if (bus.REQ_OP == 2'b01 && bus.REQ_TAPS > tap_q) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else if (bus.REQ_OP == 2'b10) begin
                        state_d = S_LOAD;
                    end else if (bus.REQ_TAPS == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_SETUP;
                        dir_d   = (bus.REQ_OP == 2'b00);
                    end
                end
            end
            S_LOAD: begin
                tap_d   = LOAD_TAP;
                cnt_d   = SETTLE_LD;
                state_d = S_SETTLE;
            end
            S_SETUP: state_d = S_MOVE;
            S_MOVE: begin
                tap_d   = dir_q ? tap_q + 1'b1 : tap_q - 1'b1;
                rem_d   = rem_q - 1'b1;
                cnt_d   = GAP_LD;
                state_d = S_GAP;
            end
            S_GAP: begin
                // IOD hit its limit: the last step did not take effect, so roll it back.
                if (oor_q) begin
                    tap_d   = dir_q ? tap_q - 1'b1 : tap_q + 1'b1;
                    err_d   = 1'b1;
                    rem_d   = '0;
                    cnt_d   = SETTLE_LD;
                    state_d = S_SETTLE;
                end else if (cnt_q == '0) begin
                    if (rem_q != '0) begin
                        state_d = S_MOVE;
                    end else begin
                        cnt_d   = SETTLE_LD;
                        state_d = S_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_FIN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.REQ_READY              = (state_q == S_IDLE);
    assign bus.BUSY                   = (state_q != S_IDLE);
    assign bus.DONE                   = (state_q == S_FIN);
    assign bus.DELAY_LINE_MOVE_0      = (state_q == S_MOVE);
    assign bus.DELAY_LINE_LOAD_0      = (state_q == S_LOAD);
    assign bus.DELAY_LINE_DIRECTION_0 = dir_q;
    assign bus.TAP_CNT                = tap_q;
    assign bus.ERR                    = err_q;
endmodule
